// File: rtl/smm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : smm_arbiter
// Description : Two-requester front end for a shared, pipelined 2x2 Strassen
//               matrix-multiply core. Grants one operand pair per cycle
//               (round robin on ties), tracks each issue through a
//               LATENCY-deep tag pipeline and returns each result through a
//               per-requester one-entry buffer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATAWIDTH  width of a packed 2x2 operand / result bus
//   BLOCKSIZE  width of one matrix element
//   LATENCY    cycles from core_load to the matching core_c
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/ready/a/b         operand handshake for requester N (N=0,1)
//   core_load, core_a, core_b    issue strobe and operands to the core
//   core_c                       result from the core
//   rspN_valid/ready/data        result handshake for requester N
//   busy                         any issue in flight or any result buffered
// ============================================================================
module smm_arbiter #(
  parameter int DATAWIDTH = 128,
  parameter int BLOCKSIZE = 32,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  // requester 0
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [DATAWIDTH-1:0] req0_b,
  // requester 1
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [DATAWIDTH-1:0] req1_b,
  // shared core
  output logic                 core_load,
  output logic [DATAWIDTH-1:0] core_a,
  output logic [DATAWIDTH-1:0] core_b,
  input  logic [DATAWIDTH-1:0] core_c,
  // responses
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [DATAWIDTH-1:0] rsp0_data,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [DATAWIDTH-1:0] rsp1_data,
  output logic                 busy
);

  localparam int c_ELEMS = DATAWIDTH / BLOCKSIZE;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]           r_inflight;
  logic [1:0]           r_full;
  logic                 r_last;       // id of the most recent grant
  logic [LATENCY-1:0]   r_tag_vld;
  logic [LATENCY-1:0]   r_tag_id;
  logic [DATAWIDTH-1:0] r_rsp0_data;
  logic [DATAWIDTH-1:0] r_rsp1_data;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [1:0]           w_elig;
  logic                 w_gnt_vld;
  logic                 w_gnt_id;
  logic [1:0]           w_gnt;
  logic                 w_cap_vld;
  logic                 w_cap_id;
  logic [1:0]           w_cap;
  logic [1:0]           w_rsp_fire;
  logic [DATAWIDTH-1:0] w_sel_a;
  logic [DATAWIDTH-1:0] w_sel_b;

  // One outstanding operation per requester: a requester whose result has not
  // yet been handed back is held off, so its buffer is always free at capture.
  assign w_elig[0] = req0_valid & ~r_inflight[0] & ~r_full[0];
  assign w_elig[1] = req1_valid & ~r_inflight[1] & ~r_full[1];

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (!rst) begin
      if (w_elig[0] && w_elig[1]) begin
        // tie: the requester that did not win last time goes now
        w_gnt_vld = 1'b1;
        w_gnt_id  = ~r_last;
      end else if (w_elig[0]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b0;
      end else if (w_elig[1]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b1;
      end
    end
  end

  assign w_gnt[0]   = w_gnt_vld & ~w_gnt_id;
  assign w_gnt[1]   = w_gnt_vld &  w_gnt_id;
  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign core_load  = w_gnt_vld;

  assign w_sel_a = w_gnt_id ? req1_a : req0_a;
  assign w_sel_b = w_gnt_id ? req1_b : req0_b;

  // Element-wise operand routing; the core sees zeros when nothing is issued.
  generate
    for (genvar e = 0; e < c_ELEMS; e++) begin : g_elem
      assign core_a[e*BLOCKSIZE +: BLOCKSIZE] =
        w_gnt_vld ? w_sel_a[e*BLOCKSIZE +: BLOCKSIZE] : '0;
      assign core_b[e*BLOCKSIZE +: BLOCKSIZE] =
        w_gnt_vld ? w_sel_b[e*BLOCKSIZE +: BLOCKSIZE] : '0;
    end
  endgenerate

  // The oldest tag lines up with the cycle in which core_c carries its result.
  assign w_cap_vld     = r_tag_vld[LATENCY-1];
  assign w_cap_id      = r_tag_id[LATENCY-1];
  assign w_cap[0]      = w_cap_vld & ~w_cap_id;
  assign w_cap[1]      = w_cap_vld &  w_cap_id;
  assign w_rsp_fire[0] = r_full[0] & rsp0_ready;
  assign w_rsp_fire[1] = r_full[1] & rsp1_ready;

  // --------------------------------------------------------------------------
  // Tag pipeline
  // --------------------------------------------------------------------------
  generate
    if (LATENCY == 1) begin : g_tag_single
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag_vld <= '0;
          r_tag_id  <= '0;
        end else begin
          r_tag_vld <= w_gnt_vld;
          r_tag_id  <= w_gnt_id;
        end
      end
    end else begin : g_tag_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag_vld <= '0;
          r_tag_id  <= '0;
        end else begin
          r_tag_vld <= {r_tag_vld[LATENCY-2:0], w_gnt_vld};
          r_tag_id  <= {r_tag_id[LATENCY-2:0],  w_gnt_id};
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbitration pointer, in-flight flags and result buffers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight  <= '0;
      r_full      <= '0;
      r_last      <= 1'b1;
      r_rsp0_data <= '0;
      r_rsp1_data <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_last <= w_gnt_id;
      end
      for (int n = 0; n < 2; n++) begin
        r_inflight[n] <= (r_inflight[n] | w_gnt[n]) & ~w_cap[n];
        r_full[n]     <= (r_full[n] & ~w_rsp_fire[n]) | w_cap[n];
      end
      if (w_cap[0]) begin
        r_rsp0_data <= core_c;
      end
      if (w_cap[1]) begin
        r_rsp1_data <= core_c;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (forced low while reset is held)
  // --------------------------------------------------------------------------
  assign rsp0_valid = r_full[0] & ~rst;
  assign rsp1_valid = r_full[1] & ~rst;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;
  assign busy       = ~rst & ((|r_tag_vld) | (|r_inflight) | (|r_full));

endmodule
`default_nettype wire

// File: tb/tb_smm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_smm_arbiter
// Description : Directed self-checking bench for smm_arbiter with a
//               behavioural 2-cycle 2x2 matrix-multiply core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smm_arbiter;

  localparam int DW = 128;

  // identity x B0 = B0 reordered into {C11,C12,C21,C22}
  localparam logic [DW-1:0] c_A0 = 128'h00000001_00000000_00000000_00000001;
  localparam logic [DW-1:0] c_B0 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [DW-1:0] c_C0 = 128'h00000001_00000002_00000003_00000004;
  // [[1,2],[3,4]] x [[5,6],[7,8]] = [[19,22],[43,50]]
  localparam logic [DW-1:0] c_A1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [DW-1:0] c_B1 = 128'h00000008_00000007_00000006_00000005;
  localparam logic [DW-1:0] c_C1 = 128'h00000013_00000016_0000002b_00000032;
  localparam logic [DW-1:0] c_JUNK = 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          core_load;
  logic [DW-1:0] core_a, core_b, core_c;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int g0_cnt, g1_cnt;

  always #5 clk = ~clk;

  smm_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .core_load  (core_load),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_c     (core_c),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .busy       (busy)
  );

  // --------------------------------------------------------------------------
  // Core model: plain 2x2 product, result valid two cycles after load.
  // Idle slots carry a junk pattern so a mistimed capture is visible.
  // --------------------------------------------------------------------------
  function automatic logic [DW-1:0] mm2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [31:0] c11, c12, c21, c22;
    c11 = a[31:0]  * b[31:0] + a[63:32]  * b[95:64];
    c12 = a[31:0]  * b[63:32] + a[63:32] * b[127:96];
    c21 = a[95:64] * b[31:0] + a[127:96] * b[95:64];
    c22 = a[95:64] * b[63:32] + a[127:96] * b[127:96];
    return {c11, c12, c21, c22};
  endfunction

  logic [DW-1:0] r_core_s0, r_core_s1;
  always @(posedge clk) begin
    r_core_s0 <= core_load ? mm2(core_a, core_b) : c_JUNK;
    r_core_s1 <= r_core_s0;
  end
  assign core_c = r_core_s1;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Leaves the bench 1 time unit into cycle 0 with rst already released.
  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a     = c_A0;
    req0_b     = c_B0;
    req1_a     = c_A1;
    req1_b     = c_B1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // outputs held low during reset even with requests pending
    next_cycle();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    settle();
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);
    check("rst_load", core_load, 1'b0);
    check("rst_core_a", core_a, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check("rst_rsp0_data", rsp0_data, '0);

    // ---- single request, identity operand
    do_reset();
    req0_valid = 1'b1;
    settle();
    check("t1_c0_ready", {req1_ready, req0_ready}, 2'b01);
    check("t1_c0_load", core_load, 1'b1);
    check("t1_c0_core_a", core_a, c_A0);
    check("t1_c0_core_b", core_b, c_B0);
    next_cycle();
    req0_valid = 1'b0;
    settle();
    check("t1_c1_load", core_load, 1'b0);
    check("t1_c1_core_a", core_a, '0);
    check("t1_c1_busy", busy, 1'b1);
    check("t1_c1_rsp0v", rsp0_valid, 1'b0);
    next_cycle();
    settle();
    check("t1_c2_rsp0v", rsp0_valid, 1'b0);
    next_cycle();
    settle();
    check("t1_c3_rsp0v", rsp0_valid, 1'b1);
    check("t1_c3_rsp0d", rsp0_data, c_C0);
    next_cycle();
    settle();
    check("t1_c4_rsp0v", rsp0_valid, 1'b0);
    check("t1_c4_busy", busy, 1'b0);

    // ---- both valid from reset: order 0 then 1
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    settle();
    check("t2_c0_ready", {req1_ready, req0_ready}, 2'b01);
    check("t2_c0_core_a", core_a, c_A0);
    next_cycle();
    req0_valid = 1'b0;
    settle();
    check("t2_c1_ready", {req1_ready, req0_ready}, 2'b10);
    check("t2_c1_core_a", core_a, c_A1);
    check("t2_c1_core_b", core_b, c_B1);
    next_cycle();
    req1_valid = 1'b0;
    settle();
    check("t2_c2_ready", {req1_ready, req0_ready}, 2'b00);
    next_cycle();
    settle();
    check("t2_c3_rspv", {rsp1_valid, rsp0_valid}, 2'b01);
    check("t2_c3_rsp0d", rsp0_data, c_C0);
    next_cycle();
    settle();
    check("t2_c4_rspv", {rsp1_valid, rsp0_valid}, 2'b10);
    check("t2_c4_rsp1d", rsp1_data, c_C1);

    // ---- both continuously valid: 0,1,-,- repeating, 20 grants
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    g0_cnt = 0;
    g1_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) next_cycle();
      settle();
      check("t3_grant", {req1_ready, req0_ready},
            (c % 4 == 0) ? 2'b01 : (c % 4 == 1) ? 2'b10 : 2'b00);
      if (req0_ready) g0_cnt++;
      if (req1_ready) g1_cnt++;
    end
    check("t3_grants0", g0_cnt, 10);
    check("t3_grants1", g1_cnt, 10);

    // ---- requester 0 stalls its response; requester 1 keeps going
    do_reset();
    rsp0_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) next_cycle();
      if (c == 13) rsp0_ready = 1'b1;
      settle();
      check("t4_ready0", req0_ready, (c == 0 || c == 14) ? 1'b1 : 1'b0);
      check("t4_ready1", req1_ready, (c % 4 == 1) ? 1'b1 : 1'b0);
      check("t4_rsp1v", rsp1_valid, (c >= 4 && c % 4 == 0) ? 1'b1 : 1'b0);
      if (c >= 4 && c % 4 == 0) check("t4_rsp1d", rsp1_data, c_C1);
      if (c >= 3 && c <= 12) begin
        check("t4_rsp0v", rsp0_valid, 1'b1);
        check("t4_rsp0d", rsp0_data, c_C0);
      end
    end

    // ---- reset one cycle after a grant
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    settle();
    check("t5_c0_ready0", req0_ready, 1'b1);
    next_cycle();
    req0_valid = 1'b0;
    rst        = 1'b1;
    settle();
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_load", core_load, 1'b0);
    next_cycle();
    rst = 1'b0;
    settle();
    check("t5_post_busy", busy, 1'b0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      settle();
      check("t5_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    end
    next_cycle();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    settle();
    check("t5_first_tie", {req1_ready, req0_ready}, 2'b01);
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
